ctr_block_dispatcher: RTL and testbench

//  Generates AES-CTR counter blocks from a loaded 128-bit IV and deals them round-robin to
//  NUM_LANES AES core input ports, one block per cycle, strictly in lane order. Generalises
//  the fixed two-core IV counter of aes256_ctr_mode_top: lane count and counter-field width
//  are parametrised, with selectable counter-overflow policy, flush-on-reload and status flags.

---
 rtl/aes_ctr_pkg.sv | 18 +
 rtl/ctr_field_incr.sv | 26 ++
 rtl/ctr_block_dispatcher.sv | 135 +++++++++++++
 tb/tb_ctr_block_dispatcher.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctr_pkg.sv
// Shared definitions for the AES-CTR counter-block dispatcher:
// block width, dispatcher state encoding and lane-index sizing.
package aes_ctr_pkg;

   localparam int BLOCK_W = 128;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      EXHAUSTED = 2'd2
   } state_t;

   // Width of a lane pointer; a single lane still needs one bit.
   function automatic int lane_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ctr_field_incr.sv
// Increments only the low CW bits of a counter block, leaving the upper
// bits untouched. o_carry flags that the field was all ones (overflow).
module ctr_field_incr
   import aes_ctr_pkg::*;
#(
   parameter int CW = 32
) (
   input  logic [BLOCK_W-1:0] i_block,
   output logic [BLOCK_W-1:0] o_block,
   output logic               o_carry
);

   logic [CW:0] w_sum;

   assign w_sum   = {1'b0, i_block[CW-1:0]} + {{CW{1'b0}}, 1'b1};
   assign o_carry = w_sum[CW];

   generate
      if (CW < BLOCK_W) begin : g_partial
         assign o_block = {i_block[BLOCK_W-1:CW], w_sum[CW-1:0]};
      end else begin : g_full
         assign o_block = w_sum[CW-1:0];
      end
   endgenerate

endmodule

// File: rtl/ctr_block_dispatcher.sv
// Generates AES-CTR counter blocks from a loaded IV and hands them to the
// AES cores strictly round-robin, one block per cycle when all are ready.
// A lane's block is held until that lane accepts; other lanes are never
// served out of turn so downstream reassembly can rely on lane order.
module ctr_block_dispatcher
   import aes_ctr_pkg::*;
#(
   parameter int NUM_LANES        = 2,
   parameter int IV_COUNTER_WIDTH = 32,
   parameter int WRAP_MODE        = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [BLOCK_W-1:0]   iv_in,
   input  logic                 enable,
   output logic [NUM_LANES-1:0] lane_valid,
   input  logic [NUM_LANES-1:0] lane_ready,
   output logic [BLOCK_W-1:0]   lane_block,
   output logic                 flush,
   output logic [63:0]          blocks_issued,
   output logic                 wrapped,
   output logic                 exhausted
);

   localparam int            LW        = lane_idx_w(NUM_LANES);
   localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [BLOCK_W-1:0]     r_counter;
   logic [LW-1:0]          r_ptr;
   logic [NUM_LANES-1:0]   r_valid;
   logic [NUM_LANES-1:0]   w_valid_next;
   logic                   r_flush;
   logic [63:0]            r_blocks;
   logic                   r_wrapped;
   logic                   r_exhausted;

   logic [BLOCK_W-1:0]     w_counter_incr;
   logic                   w_carry;
   logic                   w_accept;
   logic                   w_halt;
   logic [LW-1:0]          w_ptr_next;
   logic [NUM_LANES-1:0]   w_sel_cur;
   logic [NUM_LANES-1:0]   w_sel_nxt;

   ctr_field_incr #(
      .CW (IV_COUNTER_WIDTH)
   ) u_incr (
      .i_block (r_counter),
      .o_block (w_counter_incr),
      .o_carry (w_carry)
   );

   // Only the pointed-to lane can hold valid, so its ready alone decides.
   assign w_accept   = r_valid[r_ptr] & lane_ready[r_ptr];
   // In halt mode, accepting the all-ones block ends the sequence.
   assign w_halt     = w_accept & w_carry & (WRAP_MODE == 1);
   assign w_ptr_next = (r_ptr == LAST_LANE) ? '0 : r_ptr + 1'b1;

   // One-hot decode of the current and following lane pointer.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane_sel
         assign w_sel_cur[gi] = (r_ptr == LW'(gi));
         assign w_sel_nxt[gi] = (w_ptr_next == LW'(gi));
      end
   endgenerate

   // Next state and next lane-valid vector; load overrides everything.
   always_comb begin
      w_state_next = r_state;
      w_valid_next = r_valid;
      if (load) begin
         w_state_next = ISSUE;
         w_valid_next = '0;
      end else if (r_state == ISSUE) begin
         if (w_halt) begin
            w_state_next = EXHAUSTED;
            w_valid_next = '0;
         end else if (w_accept) begin
            w_valid_next = enable ? w_sel_nxt : '0;
         end else if ((r_valid == '0) && enable) begin
            w_valid_next = w_sel_cur;
         end
      end
   end

   // State, counter, pointer and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_counter   <= '0;
         r_ptr       <= '0;
         r_valid     <= '0;
         r_flush     <= 1'b0;
         r_blocks    <= '0;
         r_wrapped   <= 1'b0;
         r_exhausted <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_valid <= w_valid_next;
         r_flush <= load;
         if (load) begin
            r_counter   <= iv_in;
            r_ptr       <= '0;
            r_blocks    <= '0;
            r_wrapped   <= 1'b0;
            r_exhausted <= 1'b0;
         end else if (w_accept) begin
            r_counter <= w_counter_incr;
            r_ptr     <= w_ptr_next;
            if (r_blocks != '1) begin
               r_blocks <= r_blocks + 64'd1;
            end
            if (w_carry) begin
               if (WRAP_MODE == 1) begin
                  r_exhausted <= 1'b1;
               end else begin
                  r_wrapped <= 1'b1;
               end
            end
         end
      end
   end

   assign lane_valid    = r_valid;
   assign lane_block    = r_counter;
   assign flush         = r_flush;
   assign blocks_issued = r_blocks;
   assign wrapped       = r_wrapped;
   assign exhausted     = r_exhausted;

endmodule

// File: tb/tb_ctr_block_dispatcher.sv
// Scoreboard bench: expected (lane, block) pairs are queued as stimulus is
// issued; monitors pop and compare on every handshake of each instance.
module tb_ctr_block_dispatcher;

   localparam logic [127:0] IV1  = 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF;
   localparam logic [127:0] IV1P1 = 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFF00;
   localparam logic [127:0] IV1P2 = 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFF01;
   localparam logic [127:0] IV2  = 128'h01234567_89ABCDEF_00112233_FFFFFFFE;
   localparam logic [127:0] IV2P1 = 128'h01234567_89ABCDEF_00112233_FFFFFFFF;
   localparam logic [127:0] IV2P2 = 128'h01234567_89ABCDEF_00112233_00000000;
   localparam logic [127:0] IV3  = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_12345678;

   typedef struct packed {
      logic [3:0]   lane;
      logic [127:0] block;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         load0, load1, en0, en1;
   logic [127:0] iv0, iv1;
   logic [1:0]   rdy0, rdy1, vld0, vld1;
   logic [127:0] blk0, blk1;
   logic         fl0, fl1, wr0, wr1, ex0, ex1;
   logic [63:0]  bi0, bi1;

   exp_t q0[$];
   exp_t q1[$];
   int   n_tot = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   ctr_block_dispatcher #(.NUM_LANES(2), .IV_COUNTER_WIDTH(32), .WRAP_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .load(load0), .iv_in(iv0), .enable(en0),
      .lane_valid(vld0), .lane_ready(rdy0), .lane_block(blk0), .flush(fl0),
      .blocks_issued(bi0), .wrapped(wr0), .exhausted(ex0));

   ctr_block_dispatcher #(.NUM_LANES(2), .IV_COUNTER_WIDTH(32), .WRAP_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .load(load1), .iv_in(iv1), .enable(en1),
      .lane_valid(vld1), .lane_ready(rdy1), .lane_block(blk1), .flush(fl1),
      .blocks_issued(bi1), .wrapped(wr1), .exhausted(ex1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_tot++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s act=%h req=%h", name, act, req);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   task automatic push0(input int lane, input logic [127:0] b);
      exp_t e;
      e.lane = 4'(lane);
      e.block = b;
      q0.push_back(e);
   endtask

   task automatic push1(input int lane, input logic [127:0] b);
      exp_t e;
      e.lane = 4'(lane);
      e.block = b;
      q1.push_back(e);
   endtask

   // Load an IV into dut0 and check the cycle that follows the load edge.
   task automatic load_dut0(input logic [127:0] v);
      load0 = 1'b1;
      iv0 = v;
      tick();
      load0 = 1'b0;
      chk("d0_flush_after_load", 128'(fl0), 128'd1);
      chk("d0_valid_after_load", 128'(vld0), 128'd0);
      chk("d0_count_after_load", 128'(bi0), 128'd0);
   endtask

   // With all lanes ready: issue exactly n blocks, then stop.
   task automatic issue_n(input int n);
      en0 = 1'b1;
      repeat (n) tick();
      en0 = 1'b0;
      tick();
   endtask

   // dut0 handshake monitor.
   always @(negedge clk) begin
      if (!rst && !load0) begin
         if ($countones(vld0) > 1) begin
            n_tot++;
            n_bad++;
            $display("FAIL d0_onehot act=%b req=at most one bit", vld0);
         end
         for (int i = 0; i < 2; i++) begin
            if (vld0[i] && rdy0[i]) begin
               n_tot++;
               if (q0.size() == 0) begin
                  n_bad++;
                  $display("FAIL d0_unexpected act=lane%0d %h req=no transfer", i, blk0);
               end else begin
                  exp_t e;
                  e = q0.pop_front();
                  if (e.lane != 4'(i) || e.block !== blk0) begin
                     n_bad++;
                     $display("FAIL d0_xfer act=lane%0d %h req=lane%0d %h", i, blk0, e.lane, e.block);
                  end else begin
                     $display("ok   d0_xfer lane%0d %h", i, blk0);
                  end
               end
            end
         end
      end
   end

   // dut1 handshake monitor.
   always @(negedge clk) begin
      if (!rst && !load1) begin
         for (int i = 0; i < 2; i++) begin
            if (vld1[i] && rdy1[i]) begin
               n_tot++;
               if (q1.size() == 0) begin
                  n_bad++;
                  $display("FAIL d1_unexpected act=lane%0d %h req=no transfer", i, blk1);
               end else begin
                  exp_t e;
                  e = q1.pop_front();
                  if (e.lane != 4'(i) || e.block !== blk1) begin
                     n_bad++;
                     $display("FAIL d1_xfer act=lane%0d %h req=lane%0d %h", i, blk1, e.lane, e.block);
                  end else begin
                     $display("ok   d1_xfer lane%0d %h", i, blk1);
                  end
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      load0 = 1'b0; load1 = 1'b0;
      en0 = 1'b0; en1 = 1'b0;
      iv0 = '0; iv1 = '0;
      rdy0 = 2'b11; rdy1 = 2'b11;
      tick();
      tick();
      rst = 1'b0;

      // Reset state, then IDLE must not issue even with enable high.
      chk("rst_valid", 128'(vld0), 128'd0);
      chk("rst_block", blk0, 128'd0);
      chk("rst_count", 128'(bi0), 128'd0);
      chk("rst_flush", 128'(fl0), 128'd0);
      en0 = 1'b1;
      repeat (3) tick();
      chk("idle_no_valid", 128'(vld0), 128'd0);
      en0 = 1'b0;

      // Three blocks round-robin from IV1.
      push0(0, IV1); push0(1, IV1P1); push0(0, IV1P2);
      load_dut0(IV1);
      issue_n(3);
      chk("t1_count", 128'(bi0), 128'd3);
      chk("t1_idle_after", 128'(vld0), 128'd0);
      chk("t1_flush_low", 128'(fl0), 128'd0);

      // Counter field wraps, upper bits preserved.
      push0(0, IV2); push0(1, IV2P1); push0(0, IV2P2);
      load_dut0(IV2);
      issue_n(3);
      chk("t2_wrapped", 128'(wr0), 128'd1);
      chk("t2_count", 128'(bi0), 128'd3);
      chk("t2_exhausted", 128'(ex0), 128'd0);

      // Halt mode on the second instance.
      push1(0, IV2); push1(1, IV2P1);
      load1 = 1'b1;
      iv1 = IV2;
      tick();
      load1 = 1'b0;
      chk("t3_flush", 128'(fl1), 128'd1);
      en1 = 1'b1;
      repeat (6) tick();
      chk("t3_exhausted", 128'(ex1), 128'd1);
      chk("t3_count", 128'(bi1), 128'd2);
      chk("t3_no_valid", 128'(vld1), 128'd0);
      chk("t3_no_wrapped", 128'(wr1), 128'd0);
      push1(0, IV1);
      load1 = 1'b1;
      iv1 = IV1;
      tick();
      load1 = 1'b0;
      chk("t3_exh_cleared", 128'(ex1), 128'd0);
      tick();
      chk("t3_recover_valid", 128'(vld1), 128'd1);
      chk("t3_recover_block", blk1, IV1);
      en1 = 1'b0;
      tick();
      chk("t3_recover_count", 128'(bi1), 128'd1);

      // Lane 1 stalls: block held, lane 0 idle, then resumes.
      push0(0, IV1); push0(1, IV1P1);
      load_dut0(IV1);
      rdy0 = 2'b01;
      en0 = 1'b1;
      tick();
      tick();
      en0 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("t4_hold_valid", 128'(vld0), 128'd2);
         chk("t4_hold_block", blk0, IV1P1);
         tick();
      end
      chk("t4_hold_count", 128'(bi0), 128'd1);
      rdy0 = 2'b11;
      tick();
      chk("t4_resume_count", 128'(bi0), 128'd2);
      chk("t4_resume_idle", 128'(vld0), 128'd0);

      // Load aborts a pending block, even when it would be accepted.
      load_dut0(IV1);
      rdy0 = 2'b00;
      en0 = 1'b1;
      tick();
      tick();
      chk("t5_pending", 128'(vld0), 128'd1);
      chk("t5_pending_block", blk0, IV1);
      push0(0, IV3);
      rdy0 = 2'b01;
      load_dut0(IV3);
      rdy0 = 2'b00;
      tick();
      chk("t5_new_valid", 128'(vld0), 128'd1);
      chk("t5_new_block", blk0, IV3);
      chk("t5_flush_once", 128'(fl0), 128'd0);
      rdy0 = 2'b11;
      en0 = 1'b0;
      tick();
      chk("t5_count", 128'(bi0), 128'd1);

      // Reset mid-run.
      push0(0, IV1);
      load_dut0(IV1);
      en0 = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("t6_valid", 128'(vld0), 128'd0);
      chk("t6_block", blk0, 128'd0);
      chk("t6_count", 128'(bi0), 128'd0);
      chk("t6_wrapped", 128'(wr0), 128'd0);
      rst = 1'b0;
      repeat (4) tick();
      chk("t6_no_valid", 128'(vld0), 128'd0);
      en0 = 1'b0;

      // Every queued expectation must have been consumed.
      for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) tick();
      n_tot++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_bad++;
         $display("FAIL drain act=%0d/%0d left req=0/0", q0.size(), q1.size());
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
